// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter
//   Iterative RV32M/RV64M multiply/divide unit (MUL, MULH, MULHSU, MULHU, DIV,
//   DIVU, REM, REMU and the W variants). Radix-2 shift-add multiply and
//   restoring divide, one bit per cycle, on operand magnitudes with the result
//   sign applied at the end. Divide-by-zero and signed overflow finish in one
//   cycle without iterating.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   flush      kills any in-flight op; also blocks acceptance this cycle
//   in_valid   request valid           in_ready   unit can accept this cycle
//   op         RISC-V funct3           word_op    W variant (ignored if !WORD_EN)
//   a, b       rs1 / rs2 operands
//   out_valid  result valid            out_ready  consumer takes the result
//   res        result, held stable while out_valid && !out_ready
// -----------------------------------------------------------------------------
module mdu_iter #(
    parameter int XLEN    = 64,
    parameter bit WORD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res
);

    localparam int CW  = 7;          // holds iteration counts up to 64
    localparam int WSH = XLEN - 32;  // alignment offset of 32-bit ops in the datapath

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [2:0]        op_q,    op_d;
    logic              word_q,  word_d;
    logic              neg_q,   neg_d;   // negate the magnitude result at the end
    logic [XLEN-1:0]   opd_q,   opd_d;   // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q,   acc_d;   // {hi, lo}: product, or {remainder, quotient}
    logic [XLEN-1:0]   res_q,   res_d;

    function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // ---------------- request decode (combinational on the inputs) ----------
    logic            accept, word_eff, a_signed, b_signed, sa, sb;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, min_val, fast_raw, fast_res;

    assign in_ready  = (state_q == IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign res       = res_q;

    always_comb begin
        // MULH/MULHSU/MULHU have no W form; word_op on them is the plain op.
        word_eff = WORD_EN && word_op && ((op == 3'd0) || op[2]);
        a_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);

        if (word_eff) begin
            ext_a   = a_signed ? sext_w(a[31:0]) : XLEN'(a[31:0]);
            ext_b   = b_signed ? sext_w(b[31:0]) : XLEN'(b[31:0]);
            min_val = sext_w(32'h8000_0000);
        end else begin
            ext_a   = a;
            ext_b   = b;
            min_val = {1'b1, {(XLEN-1){1'b0}}};
        end

        sa    = a_signed && ext_a[XLEN-1];
        sb    = b_signed && ext_b[XLEN-1];
        mag_a = sa ? -ext_a : ext_a;
        mag_b = sb ? -ext_b : ext_b;

        div_zero = op[2] && (ext_b == '0);
        div_ovf  = op[2] && !op[0] && (ext_a == min_val) && (ext_b == '1);

        if (div_zero) begin
            fast_raw = op[1] ? ext_a : '1;
        end else begin
            fast_raw = op[1] ? '0 : ext_a;
        end
        // W results are always the sign-extended low word, even for DIVUW/REMUW.
        fast_res = word_eff ? sext_w(fast_raw[31:0]) : fast_raw;
    end

    // ---------------- one iteration step and final formatting ---------------
    logic [XLEN:0]     mul_sum, div_trial;
    logic [XLEN-1:0]   div_diff, div_raw, div_sgn, fin_raw, fin_res;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_next, div_next, mul_full, mul_sgn;

    always_comb begin
        // Multiply: add the multiplicand into the high half if the current
        // multiplier bit is set, then shift the whole accumulator right.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring divide: shift the next dividend bit into the remainder and
        // subtract the divisor when it fits; the quotient bit enters at lo[0].
        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = (div_trial >= {1'b0, opd_q});
        div_diff  = div_trial[XLEN-1:0] - opd_q;
        div_next  = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                           : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

        // A 32-step multiply leaves the product WSH bits above its true position.
        mul_full = word_q ? (acc_q >> WSH) : acc_q;
        mul_sgn  = neg_q ? -mul_full : mul_full;
        div_raw  = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        div_sgn  = neg_q ? -div_raw : div_raw;

        if (op_q[2]) begin
            fin_raw = div_sgn;
        end else if (op_q == 3'd0) begin
            fin_raw = mul_sgn[XLEN-1:0];
        end else begin
            fin_raw = mul_sgn[2*XLEN-1:XLEN];
        end
        fin_res = word_q ? sext_w(fin_raw[31:0]) : fin_raw;
    end

    // ---------------- next-state logic ---------------------------------------
    always_comb begin
        // NOTE: every *_d gets a hold value first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        word_d  = word_q;
        neg_d   = neg_q;
        opd_d   = opd_q;
        acc_d   = acc_q;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d   = op;
                    word_d = word_eff;
                    if (div_zero || div_ovf) begin
                        res_d   = fast_res;
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                        cnt_d   = word_eff ? CW'(32) : CW'(XLEN);
                        if (op[2]) begin
                            // Left-align a 32-bit dividend so its MSB is consumed first.
                            opd_d = mag_b;
                            acc_d = {{XLEN{1'b0}}, (word_eff ? (mag_a << WSH) : mag_a)};
                            neg_d = op[1] ? sa : (sa ^ sb);
                        end else begin
                            opd_d = mag_a;
                            acc_d = {{XLEN{1'b0}}, mag_b};
                            neg_d = sa ^ sb;
                        end
                    end
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Counter exhausted: sign-correct, format and publish.
                    res_d   = fin_res;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
        end
    end

    // ---------------- state registers ----------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            word_q  <= 1'b0;
            neg_q   <= 1'b0;
            opd_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            word_q  <= word_d;
            neg_q   <= neg_d;
            opd_q   <= opd_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

endmodule
